pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage LEGv8 pipeline. Drives write-enables and

---
 rtl/pipeline_hazard_ctrl_if.sv | 57 +++++
 rtl/pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the hazard inputs that the pipeline reports and the stall/flush
// controls that the hazard sequencer returns.
//   master : pipeline side. Drives ID/EX/MEM hazard information and watches
//            the controls.
//   slave  : sequencer side. Reads the hazard information and drives the
//            write enables, flushes, error flag, state and perf counters.
// Signals:
//   id_rn, id_rm, id_uses_rm     ID-stage source registers, Rm-used flag
//   ex_memread, ex_rd            EX-stage load flag and destination register
//   branch_taken                 MEM-stage branch resolved taken
//   dmem_req, dmem_ready         data-memory access active / completes
//   *_write, *_flush             pipeline register load enables / bubble loads
//   dmem_err, ctrl_state         sticky timeout error, sequencer state
//   stall_cnt, flush_cnt         perf counters (CNT_W bits)
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic             id_uses_rm;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             memwb_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             dmem_err;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rn, id_rm, id_uses_rm, ex_memread, ex_rd,
           branch_taken, dmem_req, dmem_ready,
    input  pc_write, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, exmem_flush, dmem_err, ctrl_state,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rn, id_rm, id_uses_rm, ex_memread, ex_rd,
           branch_taken, dmem_req, dmem_ready,
    output pc_write, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, exmem_flush, dmem_err, ctrl_state,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage LEGv8 pipeline. Handles load-use
// bubbles, taken-branch flushes (branch resolved in MEM) and multi-cycle
// data-memory waits, with a timeout that traps a hung memory in ERROR.
// Ports:
//   clk      clock, all state on posedge
//   reset_n  synchronous active-low reset; while low all writes are 0 and
//            all flushes are 1
//   hz       pipeline_hazard_ctrl_if.slave (hazard inputs, controls out)
// Parameters:
//   TIMEOUT_CYCLES  MEM_WAIT cycles tolerated before ERROR (>=2)
//   CNT_W           perf counter width
// Optional feature: define HAZARD_PERF_EN to build the saturating
// stall_cnt / flush_cnt counters; otherwise both read as zero.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            load_use;
  logic            mem_stall;
  logic            release_ok;

  // X31 is XZR: a load "writing" it never creates a dependency.
  assign load_use = hz.ex_memread && (hz.ex_rd != 5'd31) &&
                    ((hz.ex_rd == hz.id_rn) ||
                     (hz.id_uses_rm && (hz.ex_rd == hz.id_rm)));

  assign mem_stall = hz.dmem_req && !hz.dmem_ready;

  // Normal hazard rules apply in RUN when memory is not holding us, and on
  // the MEM_WAIT cycle in which memory finally answers.
  assign release_ok = ((state_q == ST_RUN)  && !mem_stall) ||
                      ((state_q == ST_WAIT) && hz.dmem_ready);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_WAIT;
          cnt_d   = TW'(1);
        end
      end
      ST_WAIT: begin
        // Ready takes precedence even on the cycle the limit is reached.
        if (hz.dmem_ready) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      ST_ERR:  ;
      default: state_d = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    hz.pc_write    = 1'b0;
    hz.ifid_write  = 1'b0;
    hz.idex_write  = 1'b0;
    hz.exmem_write = 1'b0;
    hz.memwb_write = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.exmem_flush = 1'b0;
    if (!reset_n) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_flush  = 1'b1;
      hz.exmem_flush = 1'b1;
    end else if (release_ok) begin
      hz.pc_write    = 1'b1;
      hz.ifid_write  = 1'b1;
      hz.idex_write  = 1'b1;
      hz.exmem_write = 1'b1;
      hz.memwb_write = 1'b1;
      if (hz.branch_taken) begin
        // Kill the three wrong-path instructions behind the branch.
        hz.ifid_flush  = 1'b1;
        hz.idex_flush  = 1'b1;
        hz.exmem_flush = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID one cycle, insert one bubble into EX.
        hz.pc_write   = 1'b0;
        hz.ifid_write = 1'b0;
        hz.idex_flush = 1'b1;
      end
    end
    // Otherwise (memory wait, error) everything stays frozen.
  end

  assign hz.dmem_err   = err_q;
  assign hz.ctrl_state = state_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // exmem_flush outside reset is only ever raised by a branch flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hz.pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (hz.exmem_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl with TIMEOUT_CYCLES=4. Inputs are
// changed 1ns after each rising edge; outputs are sampled on the falling
// edge. The control bundle is compared as
// {pc,ifid,idex,exmem,memwb write, ifid,idex,exmem flush}.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [7:0] W_RUN = 8'b11111_000;
  localparam logic [7:0] W_FRZ = 8'b00000_000;
  localparam logic [7:0] W_LU  = 8'b00111_010;
  localparam logic [7:0] W_BR  = 8'b11111_111;
  localparam logic [7:0] W_RST = 8'b00000_111;

  logic clk;
  logic reset_n;
  int   total;
  int   passed;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(
    .TIMEOUT_CYCLES(4),
    .CNT_W         (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ctl;
  assign ctl = {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exmem_write,
                hz.memwb_write, hz.ifid_flush, hz.idex_flush, hz.exmem_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset_n = 1'b0;
    hz.id_rn = 5'd0;
    hz.id_rm = 5'd0;
    hz.id_uses_rm = 1'b0;
    hz.ex_memread = 1'b0;
    hz.ex_rd = 5'd0;
    hz.branch_taken = 1'b0;
    hz.dmem_req = 1'b0;
    hz.dmem_ready = 1'b0;

    // Reset state
    @(posedge clk);
    smp();
    chk("rst_ctl", 32'(ctl), 32'(W_RST));
    chk("rst_state", 32'(hz.ctrl_state), 32'd0);
    chk("rst_err", 32'(hz.dmem_err), 32'd0);
    chk("rst_stall_cnt", hz.stall_cnt, 32'd0);
    chk("rst_flush_cnt", hz.flush_cnt, 32'd0);

    go(); reset_n = 1'b1;
    smp(); chk("idle", 32'(ctl), 32'(W_RUN));

    // Load-use on Rn, then the bubble clears it
    go(); hz.ex_memread = 1'b1; hz.ex_rd = 5'd3; hz.id_rn = 5'd3;
    smp(); chk("lu_rn", 32'(ctl), 32'(W_LU));
    go(); hz.ex_memread = 1'b0;
    smp(); chk("lu_clear", 32'(ctl), 32'(W_RUN));

    // Load-use on Rm only when Rm is read
    go(); hz.ex_memread = 1'b1; hz.ex_rd = 5'd5; hz.id_rn = 5'd2; hz.id_rm = 5'd5; hz.id_uses_rm = 1'b1;
    smp(); chk("lu_rm", 32'(ctl), 32'(W_LU));
    go(); hz.id_uses_rm = 1'b0;
    smp(); chk("rm_unused", 32'(ctl), 32'(W_RUN));

    // XZR never hazards
    go(); hz.ex_rd = 5'd31; hz.id_rn = 5'd31; hz.id_rm = 5'd31; hz.id_uses_rm = 1'b1;
    smp(); chk("xzr", 32'(ctl), 32'(W_RUN));

    // Taken branch, one cycle
    go(); hz.ex_memread = 1'b0; hz.branch_taken = 1'b1;
    smp(); chk("branch", 32'(ctl), 32'(W_BR));
    go(); hz.branch_taken = 1'b0;
    smp(); chk("branch_done", 32'(ctl), 32'(W_RUN));

    // Branch beats load-use
    go(); hz.branch_taken = 1'b1; hz.ex_memread = 1'b1; hz.ex_rd = 5'd3; hz.id_rn = 5'd3;
    smp(); chk("br_over_lu", 32'(ctl), 32'(W_BR));

    // Memory wait released at the timeout limit: ready wins
    go(); hz.branch_taken = 1'b0; hz.ex_memread = 1'b0; hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
    smp(); chk("wait_entry_ctl", 32'(ctl), 32'(W_FRZ));
    chk("wait_entry_state", 32'(hz.ctrl_state), 32'd0);
    for (int i = 0; i < 3; i++) begin
      go();
      smp(); chk("wait_frozen_ctl", 32'(ctl), 32'(W_FRZ));
      chk("wait_frozen_state", 32'(hz.ctrl_state), 32'd1);
    end
    go(); hz.dmem_ready = 1'b1;
    smp(); chk("release_ctl", 32'(ctl), 32'(W_RUN));
    chk("release_state", 32'(hz.ctrl_state), 32'd1);
    go(); hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
    smp(); chk("back_run", 32'(hz.ctrl_state), 32'd0);
    chk("back_run_err", 32'(hz.dmem_err), 32'd0);
    // Stalls: 2 load-use + 1 entry + 3 frozen; flushes: 2 branches
    chk("stall_cnt", hz.stall_cnt, PERF ? 32'd6 : 32'd0);
    chk("flush_cnt", hz.flush_cnt, PERF ? 32'd2 : 32'd0);

    // Branch pending while frozen applies on the release cycle
    go(); hz.dmem_req = 1'b1; hz.branch_taken = 1'b1;
    smp(); chk("br_wait_entry", 32'(ctl), 32'(W_FRZ));
    go();
    smp(); chk("br_wait_frozen", 32'(ctl), 32'(W_FRZ));
    go(); hz.dmem_ready = 1'b1;
    smp(); chk("br_release", 32'(ctl), 32'(W_BR));
    go(); hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0; hz.branch_taken = 1'b0;
    smp(); chk("br_back_run", 32'(hz.ctrl_state), 32'd0);
    chk("flush_cnt_3", hz.flush_cnt, PERF ? 32'd3 : 32'd0);

    // Zero-wait access
    go(); hz.dmem_req = 1'b1; hz.dmem_ready = 1'b1;
    smp(); chk("zero_wait_ctl", 32'(ctl), 32'(W_RUN));
    go(); hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
    smp(); chk("zero_wait_state", 32'(hz.ctrl_state), 32'd0);

    // Timeout: 4 wait cycles then ERROR, sticky until reset
    go(); hz.dmem_req = 1'b1;
    smp(); chk("to_entry", 32'(ctl), 32'(W_FRZ));
    for (int i = 0; i < 4; i++) begin
      go();
      smp(); chk("to_wait_state", 32'(hz.ctrl_state), 32'd1);
      chk("to_wait_err", 32'(hz.dmem_err), 32'd0);
    end
    go();
    smp(); chk("to_err_state", 32'(hz.ctrl_state), 32'd2);
    chk("to_err_flag", 32'(hz.dmem_err), 32'd1);
    chk("to_err_ctl", 32'(ctl), 32'(W_FRZ));
    go(); hz.dmem_ready = 1'b1;
    smp(); chk("err_sticky_state", 32'(hz.ctrl_state), 32'd2);
    chk("err_sticky_flag", 32'(hz.dmem_err), 32'd1);
    chk("err_sticky_ctl", 32'(ctl), 32'(W_FRZ));

    go(); reset_n = 1'b0; hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;
    smp(); chk("err_rst_ctl", 32'(ctl), 32'(W_RST));
    go(); reset_n = 1'b1;
    smp(); chk("err_rst_state", 32'(hz.ctrl_state), 32'd0);
    chk("err_rst_flag", 32'(hz.dmem_err), 32'd0);
    chk("err_rst_run", 32'(ctl), 32'(W_RUN));

    // Reset in the middle of a memory wait
    go(); hz.dmem_req = 1'b1;
    smp(); chk("mw_entry", 32'(ctl), 32'(W_FRZ));
    go();
    smp(); chk("mw_state", 32'(hz.ctrl_state), 32'd1);
    go(); reset_n = 1'b0;
    smp(); chk("mw_rst_ctl", 32'(ctl), 32'(W_RST));
    go();
    smp(); chk("mw_rst_state", 32'(hz.ctrl_state), 32'd0);
    chk("mw_rst_ctl_held", 32'(ctl), 32'(W_RST));
    chk("mw_rst_stall_cnt", hz.stall_cnt, 32'd0);
    go(); reset_n = 1'b1; hz.dmem_req = 1'b0;
    smp(); chk("mw_after_ctl", 32'(ctl), 32'(W_RUN));
    chk("mw_after_err", 32'(hz.dmem_err), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog: the directed sequence is a few dozen cycles long.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
